// File: rtl/hazard_tracker_if.sv
// D-stage hazard bundle: decoder-side operand/writer info in, stall/forward selects out.
// Latency: none, plain wires between the decoder and the tracker.
// Backpressure: stall is the only flow control; the master freezes D while it is high.
interface hazard_tracker_if #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter int SEL_W  = 2
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [1:0]        d_rs_tuse;
  logic [1:0]        d_rt_tuse;
  logic              d_wr_en;
  logic [REG_AW-1:0] d_wr_addr;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse,
    output d_wr_en, d_wr_addr, d_tnew,
    output d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse,
    input  d_wr_en, d_wr_addr, d_tnew,
    input  d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_tracker.sv
// Decode-stage hazard unit: Tuse/Tnew scoreboard of E..W writers, stall + forward selects.
// Latency: outputs are combinational from state and D inputs; state updates on rising clk.
// Backpressure: stall freezes PC/D and inserts a bubble into E; HAZARD_MD_EN adds mult/div busy.
module hazard_tracker #(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter int TNEW_W  = 2,
  parameter int SEL_W   = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input logic             clk,
  input logic             reset,
  hazard_tracker_if.slave hz
);

  // Tuse is 2 bits wide; compare it against Tnew in a width that holds both.
  localparam int CMP_W = (TNEW_W > 2) ? TNEW_W : 2;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] addr;
    logic [TNEW_W-1:0] tnew;
  } sb_entry_t;

  sb_entry_t sb_q [1:STAGES];
  sb_entry_t sb_d [1:STAGES];

  logic              issue;
  logic              md_busy;
  logic              md_stall;
  logic              rs_hit, rt_hit;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic [SEL_W-1:0]  rs_k, rt_k;
  logic              rs_stall, rt_stall;
  logic [SEL_W-1:0]  rs_fwd, rt_fwd;

  // Youngest-match search: scan oldest to youngest so the lowest k overwrites.
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = '0;
    rs_k    = '0;
    rt_hit  = 1'b0;
    rt_tnew = '0;
    rt_k    = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (sb_q[k].vld && (sb_q[k].addr == hz.d_rs) &&
          (hz.d_rs != '0) && (hz.d_rs_tuse != 2'd3)) begin
        rs_hit  = 1'b1;
        rs_tnew = sb_q[k].tnew;
        rs_k    = SEL_W'(k);
      end
      if (sb_q[k].vld && (sb_q[k].addr == hz.d_rt) &&
          (hz.d_rt != '0) && (hz.d_rt_tuse != 2'd3)) begin
        rt_hit  = 1'b1;
        rt_tnew = sb_q[k].tnew;
        rt_k    = SEL_W'(k);
      end
    end
  end

  // An operand waits while its producer needs longer than the consumer can tolerate;
  // it forwards from the producer's stage once the value is ready (tnew reached 0).
  always_comb begin
    rs_stall = rs_hit && (CMP_W'(hz.d_rs_tuse) < CMP_W'(rs_tnew));
    rt_stall = rt_hit && (CMP_W'(hz.d_rt_tuse) < CMP_W'(rt_tnew));
    rs_fwd   = (rs_hit && (rs_tnew == '0)) ? rs_k : '0;
    rt_fwd   = (rt_hit && (rt_tnew == '0)) ? rt_k : '0;
  end

  // Output stage: nothing is reported for an empty D slot.
  always_comb begin
    hz.stall      = hz.d_valid & (rs_stall | rt_stall | md_stall);
    hz.fwd_rs_sel = hz.d_valid ? rs_fwd : '0;
    hz.fwd_rt_sel = hz.d_valid ? rt_fwd : '0;
    hz.md_busy    = md_busy;
  end

  assign issue = hz.d_valid & ~hz.stall;

  // Scoreboard advance: new writer (or bubble) enters E, older entries age by one stage.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      sb_d[k] = '0;
    end
    if (issue) begin
      sb_d[1].vld  = hz.d_wr_en && (hz.d_wr_addr != '0);
      sb_d[1].addr = hz.d_wr_addr;
      sb_d[1].tnew = hz.d_tnew;
    end
    for (int k = 2; k <= STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
      if (sb_q[k-1].tnew != '0) begin
        sb_d[k].tnew = sb_q[k-1].tnew - TNEW_W'(1);
      end
    end
  end

  // Scoreboard register; reset invalidates every in-flight writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

`ifdef HAZARD_MD_EN
  localparam int MD_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int MD_CW  = $clog2(MD_MAX + 1);

  logic [MD_CW-1:0] md_cnt_q, md_cnt_d;

  // Busy counter: an accepted start reloads it (wins over the countdown), else count to 0.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && hz.d_md_start) begin
      md_cnt_d = hz.d_md_div ? MD_CW'(DIV_CYC) : MD_CW'(MUL_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CW'(1);
    end
  end

  // Busy counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = hz.d_md_use & md_busy;
`else
  // Without the mult/div unit the HI/LO inputs are don't-care.
  localparam int unused_md_cyc = MUL_CYC + DIV_CYC;
  logic unused_md;
  assign unused_md = hz.d_md_start ^ hz.d_md_div ^ hz.d_md_use;
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: lw-use, ALU forwarding, youngest match, $0, mult/div, reset.
// Latency: checks are taken 1-2 time units after the rising edge, away from it.
// Backpressure: expected stall patterns are hand-derived per step; MD results follow HAZARD_MD_EN.
module tb_hazard_tracker;

`ifdef HAZARD_MD_EN
  localparam logic MD = 1'b1;
`else
  localparam logic MD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  hazard_tracker_if #(.REG_AW(5), .TNEW_W(2), .SEL_W(2)) hif ();

  hazard_tracker #(
    .REG_AW(5), .STAGES(3), .TNEW_W(2), .SEL_W(2), .MUL_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rs_tu,
                       input logic [4:0] rt, input logic [1:0] rt_tu,
                       input logic we, input logic [4:0] wa, input logic [1:0] tn,
                       input logic ms, input logic mdv, input logic mu);
    hif.d_valid    = v;
    hif.d_rs       = rs;
    hif.d_rs_tuse  = rs_tu;
    hif.d_rt       = rt;
    hif.d_rt_tuse  = rt_tu;
    hif.d_wr_en    = we;
    hif.d_wr_addr  = wa;
    hif.d_tnew     = tn;
    hif.d_md_start = ms;
    hif.d_md_div   = mdv;
    hif.d_md_use   = mu;
  endtask

  task automatic chk(input string tag, input logic es, input logic [1:0] ers,
                     input logic [1:0] ert, input logic eb);
    vectors++;
    assert (hif.stall === es) else begin
      miscompares++;
      $error("FAIL %s stall: observed %0b expected %0b", tag, hif.stall, es);
    end
    vectors++;
    assert (hif.fwd_rs_sel === ers) else begin
      miscompares++;
      $error("FAIL %s fwd_rs_sel: observed %0d expected %0d", tag, hif.fwd_rs_sel, ers);
    end
    vectors++;
    assert (hif.fwd_rt_sel === ert) else begin
      miscompares++;
      $error("FAIL %s fwd_rt_sel: observed %0d expected %0d", tag, hif.fwd_rt_sel, ert);
    end
    vectors++;
    assert (hif.md_busy === eb) else begin
      miscompares++;
      $error("FAIL %s md_busy: observed %0b expected %0b", tag, hif.md_busy, eb);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // lw $8 (tnew 2), then beq rs=$8 (tuse 0): two stall cycles, then forward from W.
    drive(1, 0, 1, 0, 3, 1, 8, 2, 0, 0, 0);
    #1 chk("lw_issue", 0, 0, 0, 0);
    tick();
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lwuse_e", 1, 0, 0, 0);
    tick();
    #1 chk("lwuse_m", 1, 0, 0, 0);
    tick();
    drive(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("novalid", 0, 0, 0, 0);
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lwuse_w", 0, 3, 0, 0);
    tick();
    drive(1, 8, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("lw_gone", 0, 0, 0, 0);
    tick();

    // add $9 (tnew 1): consumer in next slot neither stalls nor forwards; later ones forward.
    drive(1, 0, 1, 0, 1, 1, 9, 1, 0, 0, 0);
    #1 chk("alu_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_e", 0, 0, 0, 0);
    tick();
    drive(1, 9, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_m", 0, 2, 2, 0);
    tick();
    drive(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_w", 0, 3, 0, 0);
    tick();

    // ori $5 then lui $5: the lui entry is the one selected.
    drive(1, 0, 1, 0, 3, 1, 5, 1, 0, 0, 0);
    #1 chk("ori_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0);
    #1 chk("lui_issue", 0, 0, 0, 0);
    tick();
    drive(1, 5, 1, 5, 1, 1, 0, 1, 0, 0, 0);
    #1 chk("young_e", 0, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 0, 2, 0, 0, 0);
    #1 chk("young_m", 0, 2, 0, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("zero_reg", 0, 0, 3, 0);
    tick();

    // div then mfhi: 10 busy/stall cycles when the unit is built.
    drive(1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
    #1 chk("div_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, 3, 0, 3, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      #1 chk("div_busy", MD, 0, 0, MD);
      tick();
    end
    #1 chk("div_done", 0, 0, 0, 0);
    tick();

    // mult then mfhi: 5 cycles.
    drive(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    #1 chk("mul_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, 3, 0, 3, 1, 10, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("mul_busy", MD, 0, 0, MD);
      tick();
    end
    #1 chk("mul_done", 0, 0, 0, 0);
    tick();

    // Reset while a div is busy and lw $7 sits in M.
    drive(1, 0, 1, 0, 3, 1, 7, 2, 0, 0, 0);
    #1 chk("rst_lw", 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
    #1 chk("rst_div", 0, 0, 0, 0);
    tick();
    drive(1, 7, 0, 0, 3, 0, 0, 0, 0, 0, 1);
    #1 chk("pre_rst", 1, 0, 0, MD);
    #1 reset = 1'b1;
    #1 chk("rst_async", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1 chk("rst_after", 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
